// File: rtl/keccak_pad_absorb.sv
// Keccak message padder and rate-block assembler.
// Packs little-endian message words into a 1344-bit rate buffer. On the final
// word it applies the SHA3 (0x06) or SHAKE (0x1F) domain suffix and the 0x80
// end marker, then hands complete rate blocks downstream with valid/ready.
// When the final word exactly fills a block, a separate pad-only block follows.
module keccak_pad_absorb #(
  parameter int W  = 64,
  parameter int BW = $clog2(W/8)+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [BW-1:0] in_bytes,
  input  logic [2:0]    cmode,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [1343:0] blk_data,
  output logic          blk_first,
  output logic          blk_last,
  output logic          err_mode
);

  localparam int NB     = W/8;
  localparam int NWORDS = 1344/W;
  localparam int NBYTES = 168;
  localparam logic [7:0] NB8 = 8'(NB);

  typedef enum logic [2:0] {IDLE, FILL, EMIT, PADBLK, DROP} state_t;

  state_t        state_q, state_d;
  logic [1343:0] buf_q, buf_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [2:0]    mode_q, mode_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          padPend_q, padPend_d;
  logic          err_q, err_d;

  logic          accept;
  logic          legal;
  logic [2:0]    effMode;
  logic [7:0]    rate;
  logic [7:0]    suffix;
  logic [7:0]    inBytesExt;
  logic [7:0]    nBytes;
  logic [7:0]    qPtr;
  logic [W-1:0]  maskedData;
  logic [1343:0] wrBuf;
  logic [1343:0] padBuf;
  logic [1343:0] padOnly;

  // Rate in bytes for each capacity mode; illegal modes map to zero.
  function automatic logic [7:0] rateOf(input logic [2:0] m);
    case (m)
      3'd0:    rateOf = 8'd144;
      3'd1:    rateOf = 8'd136;
      3'd2:    rateOf = 8'd104;
      3'd3:    rateOf = 8'd72;
      3'd4:    rateOf = 8'd168;
      3'd5:    rateOf = 8'd136;
      default: rateOf = 8'd0;
    endcase
  endfunction

  // Domain-separation suffix: SHAKE modes use 0x1F, fixed-length SHA3 uses 0x06.
  function automatic logic [7:0] suffixOf(input logic [2:0] m);
    suffixOf = (m >= 3'd4) ? 8'h1F : 8'h06;
  endfunction

  assign accept    = in_valid & in_ready;
  assign legal     = (cmode < 3'd6);
  assign in_ready  = ~rst & ((state_q == IDLE) | (state_q == FILL) | (state_q == DROP));
  assign blk_valid = (state_q == EMIT) | (state_q == PADBLK);
  assign blk_data  = buf_q;
  assign blk_first = blk_valid & first_q;
  assign blk_last  = blk_valid & last_q;
  assign err_mode  = err_q;

  // Datapath: mask the incoming word, drop it into the buffer at the byte
  // pointer, and precompute the padded and pad-only variants of the buffer.
  always_comb begin
    effMode    = (state_q == IDLE) ? cmode : mode_q;
    rate       = rateOf(effMode);
    suffix     = suffixOf(effMode);
    inBytesExt = 8'(in_bytes);
    if (!in_last || inBytesExt > NB8) nBytes = NB8;
    else                              nBytes = inBytesExt;
    qPtr = ptr_q + nBytes;

    maskedData = '0;
    for (int j = 0; j < NB; j++) begin
      if (8'(j) < nBytes) maskedData[8*j +: 8] = in_data[8*j +: 8];
    end

    wrBuf = buf_q;
    for (int w = 0; w < NWORDS; w++) begin
      if (8'(w*NB) == ptr_q) wrBuf[w*W +: W] = maskedData;
    end

    padBuf  = wrBuf;
    padOnly = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (8'(k) == qPtr) padBuf[8*k +: 8] = padBuf[8*k +: 8] | suffix;
      if (8'(k) == rate - 8'd1) begin
        padBuf[8*k +: 8]  = padBuf[8*k +: 8] | 8'h80;
        padOnly[8*k +: 8] = 8'h80;
      end
    end
    padOnly[7:0] = padOnly[7:0] | suffix;
  end

  // Next-state logic: absorb words, decide when a block is complete, and
  // sequence block handoff including the trailing pad-only block.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    first_d   = first_q;
    last_d    = last_q;
    padPend_d = padPend_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE, FILL: begin
        if (accept && state_q == IDLE && !legal) begin
          err_d   = 1'b1;
          state_d = in_last ? IDLE : DROP;
        end else if (accept) begin
          if (state_q == IDLE) begin
            mode_d  = cmode;
            first_d = 1'b1;
          end
          if (in_last) begin
            state_d = EMIT;
            ptr_d   = qPtr;
            if (qPtr == rate) begin
              buf_d     = wrBuf;
              last_d    = 1'b0;
              padPend_d = 1'b1;
            end else begin
              buf_d     = padBuf;
              last_d    = 1'b1;
              padPend_d = 1'b0;
            end
          end else begin
            buf_d     = wrBuf;
            ptr_d     = qPtr;
            last_d    = 1'b0;
            padPend_d = 1'b0;
            state_d   = (qPtr == rate) ? EMIT : FILL;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d   = '0;
          ptr_d   = 8'd0;
          first_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else if (padPend_q) begin
            buf_d     = padOnly;
            last_d    = 1'b1;
            padPend_d = 1'b0;
            state_d   = PADBLK;
          end else begin
            state_d = FILL;
          end
        end
      end
      PADBLK: begin
        if (blk_ready) begin
          buf_d   = '0;
          ptr_d   = 8'd0;
          first_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any partial message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      ptr_q     <= 8'd0;
      mode_q    <= 3'd0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      padPend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
      first_q   <= first_d;
      last_q    <= last_d;
      padPend_q <= padPend_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/keccak_pad_absorb.md
KECCAK_PAD_ABSORB -- requirements
Module: keccak_pad_absorb

Interface
REQ-001 Parameter W, default 64: input word width; legal values 32 or 64.
REQ-002 Parameter BW, default $clog2(W/8)+1: width of in_bytes.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data/in_last/in_bytes/cmode valid this cycle.
REQ-006 in_ready  output  1  block accepts a word; transfer occurs when in_valid&in_ready.
REQ-007 in_data  input  W  message word; little-endian byte lanes; lane 0 = bits [7:0].
REQ-008 in_last  input  1  final word of message.
REQ-009 in_bytes  input  BW  valid bytes in final word (0..W/8, low lanes); ignored when in_last=0.
REQ-010 cmode  input  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; 6-7 illegal.
REQ-011 blk_valid  output  1  padded rate block available.
REQ-012 blk_ready  input  1  downstream (VSX/permutation) accepts block.
REQ-013 blk_data  output  1344  rate block; byte k = bits [8k+7:8k]; bits above rate are 0.
REQ-014 blk_first  output  1  block is first of its message.
REQ-015 blk_last  output  1  block is final (carries padding).
REQ-016 err_mode  output  1  one-cycle pulse: illegal cmode at message start.

Function
REQ-017 Rate R bytes by cmode: 144, 136, 104, 72, 168, 136; R/(W/8) words per block (W=64: 18,17,13,9,21,17).
REQ-018 cmode SHALL be latched on the first accepted word of a message; later changes ignored until message ends.
REQ-019 States IDLE, FILL, EMIT, PADBLK, DROP; in_ready=1 only in IDLE, FILL, DROP.
REQ-020 Accepted word with in_last=0 SHALL write all W/8 bytes at current byte pointer p, p += W/8.
REQ-021 Accepted word with in_last=1 SHALL write min(in_bytes, W/8) bytes; in_bytes > W/8 treated as W/8; 0 allowed.
REQ-022 When p reaches R without in_last: go to EMIT with blk_last=0, next cycle blk_valid=1.
REQ-023 On last word with final pointer q < R: buffer byte q |= suffix (0x06 SHA3, 0x1F SHAKE), byte R-1 |= 0x80, go to EMIT with blk_last=1.
REQ-024 q = R-1: single byte = suffix|0x80 (0x86 or 0x9F).
REQ-025 q = R: emit data block with blk_last=0, then go to PADBLK: pad-only block (byte0=suffix, byte R-1=0x80) with blk_last=1.
REQ-026 blk_valid SHALL rise the cycle after the completing word is accepted; latency 1.
REQ-027 blk_data/blk_first/blk_last SHALL hold stable while blk_valid=1 and blk_ready=0.
REQ-028 On blk_valid&blk_ready: buffer zeroed, p=0; next state FILL (message continues), PADBLK (REQ-025), or IDLE (blk_last was 1); pad-only block valid the cycle after handshake.
REQ-029 blk_first=1 only on first block emitted per message, including single-block and pad-only-as-second cases.
REQ-030 Illegal cmode on first word: err_mode pulses the following cycle; DROP consumes words until in_last accepted, then IDLE; no blk_valid.
REQ-031 Final word arriving at a word-aligned position is legal for any in_bytes; bytes beyond in_bytes SHALL be zero regardless of in_data.

Reset
REQ-032 rst=1 at clock edge: state IDLE, buffer zero, p=0, latched mode cleared; in_ready, blk_valid, blk_first, blk_last, err_mode = 0, blk_data = 0.
REQ-033 Reset mid-message or mid-EMIT SHALL discard partial data; first word after reset starts a new message.

Verification
REQ-034 W=64, cmode=5, one word in_last=1 in_bytes=0 -> one block: byte0=0x1F, byte135=0x80, rest 0, blk_first=blk_last=1.
REQ-035 cmode=1, in_data=0x636261 in_bytes=3 last -> bytes0-2=61 62 63, byte3=0x06, byte135=0x80.
REQ-036 cmode=3, 9 full words of 0xFF, last with in_bytes=8 -> block A: 72 bytes 0xFF, blk_first=1, blk_last=0; block B: byte0=0x06, byte71=0x80, blk_first=0, blk_last=1.
REQ-037 cmode=3, 8 full words + last in_bytes=7 -> byte71=0x86, single block.
REQ-038 blk_ready held 0 for 5 cycles -> blk_data stable, in_ready=0; cmode=6 message -> err_mode one pulse, no blk_valid, in_ready=1 until in_last.
REQ-039 rst asserted after 5 words of cmode=4 -> all outputs 0 next cycle; following 1-byte message 0x00 yields byte1=0x1F, byte167=0x80.
